// File: rtl/memory_arbiter_if.sv
// Cache-side and RAM-side signal bundle for the multi-core RAM arbiter.
// The arbiter connects through the slave modport; the cores and RAM model use master.
interface memory_arbiter_if #(
  parameter int unsigned CPUS = 2
);
  localparam int unsigned CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  logic [CPUS-1:0]    iREN;
  logic [CPUS*32-1:0] iaddr;
  logic [CPUS-1:0]    iwait;
  logic [CPUS*32-1:0] iload;
  logic [CPUS-1:0]    dREN;
  logic [CPUS-1:0]    dWEN;
  logic [CPUS*32-1:0] daddr;
  logic [CPUS*32-1:0] dstore;
  logic [CPUS-1:0]    dwait;
  logic [CPUS*32-1:0] dload;
  logic               ramREN;
  logic               ramWEN;
  logic [31:0]        ramaddr;
  logic [31:0]        ramstore;
  logic [31:0]        ramload;
  logic [1:0]         ramstate;
  logic [CW-1:0]      gnt_core;
  logic               gnt_valid;
  logic               mem_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
    output gnt_core, gnt_valid, mem_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
    input  gnt_core, gnt_valid, mem_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter from per-core instruction/data request ports onto one shared RAM port.
// Data beats instruction within a core; a grant ends on ACCESS, ERROR, timeout or request drop.
module memory_arbiter #(
  parameter int unsigned CPUS    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave bus
);
  localparam int unsigned CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] AbortWord = 32'hBAD1BAD1;

  typedef enum logic [1:0] {RamFree, RamBusy, RamAccess, RamError} ramstate_t;
  typedef enum logic {StIdle, StBusy} state_t;

  state_t        state_q;
  logic [CW-1:0] rr_ptr_q;
  logic [CW-1:0] gnt_core_q;
  logic          gnt_data_q;
  logic [TW-1:0] tmo_q;
  logic          mem_err_q;

  ramstate_t       rs;
  logic [CPUS-1:0] dreq;
  logic            busy;
  logic [CW-1:0]   sel_core;
  logic            sel_found;
  logic            gnt_req;
  logic            drop;
  logic            err_hit;
  logic            acc_hit;
  logic            tmo_hit;
  logic            abort;
  logic            finish;
  logic [CW-1:0]   next_ptr;

  assign rs   = ramstate_t'(bus.ramstate);
  assign dreq = bus.dREN | bus.dWEN;
  assign busy = (state_q == StBusy);

  // First requesting core at or after rr_ptr, wrapping modulo CPUS.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_core  = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < CPUS; i++) begin
      idx = (32'(rr_ptr_q) + i) % CPUS;
      if (!sel_found && (dreq[idx] || bus.iREN[idx])) begin
        sel_found = 1'b1;
        sel_core  = CW'(idx);
      end
    end
  end

  // Drop outranks ERROR, which outranks ACCESS, which outranks timeout.
  assign gnt_req  = gnt_data_q ? dreq[gnt_core_q] : bus.iREN[gnt_core_q];
  assign drop     = busy && !gnt_req;
  assign err_hit  = busy && !drop && (rs == RamError);
  assign acc_hit  = busy && !drop && !err_hit && (rs == RamAccess);
  assign tmo_hit  = busy && !drop && !err_hit && !acc_hit && (tmo_q == TW'(TIMEOUT - 1));
  assign abort    = err_hit || tmo_hit;
  assign finish   = acc_hit || abort;
  assign next_ptr = (gnt_core_q == CW'(CPUS - 1)) ? '0 : gnt_core_q + CW'(1);

  always_comb begin
    int unsigned g;
    g            = 32'(gnt_core_q);
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (busy && !drop) begin
      if (gnt_data_q) begin
        // A simultaneous read and write is treated as a write.
        bus.ramWEN   = bus.dWEN[g];
        bus.ramREN   = bus.dREN[g] && !bus.dWEN[g];
        bus.ramaddr  = bus.daddr[32*g +: 32];
        bus.ramstore = bus.dstore[32*g +: 32];
      end else begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr[32*g +: 32];
      end
    end
    if (finish) begin
      if (gnt_data_q) begin
        bus.dwait[g]           = 1'b0;
        bus.dload[32*g +: 32]  = abort ? AbortWord : bus.ramload;
      end else begin
        bus.iwait[g]           = 1'b0;
        bus.iload[32*g +: 32]  = abort ? AbortWord : bus.ramload;
      end
    end
  end

  assign bus.gnt_core  = gnt_core_q;
  assign bus.gnt_valid = busy;
  assign bus.mem_err   = mem_err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      gnt_core_q <= '0;
      gnt_data_q <= 1'b0;
      tmo_q      <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            state_q    <= StBusy;
            gnt_core_q <= sel_core;
            gnt_data_q <= dreq[sel_core];
            tmo_q      <= '0;
          end
        end
        StBusy: begin
          if (tmo_q < TW'(TIMEOUT)) begin
            tmo_q <= tmo_q + TW'(1);
          end
          if (drop || finish) begin
            state_q    <= StIdle;
            gnt_core_q <= '0;
            gnt_data_q <= 1'b0;
          end
          if (finish) begin
            rr_ptr_q <= next_ptr;
          end
          if (abort) begin
            mem_err_q <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus queues expected completions, a negedge
// monitor pops and compares whenever a requester sees its wait go low.
module tb_memory_arbiter;
  localparam int unsigned CPUS = 2;
  localparam logic [1:0] RsFree = 2'd0, RsBusy = 2'd1, RsAccess = 2'd2, RsError = 2'd3;

  typedef struct {
    int          core;
    bit          data;
    logic [31:0] load;
    logic [31:0] addr;
    logic [31:0] store;
    bit          ren;
    bit          wen;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  memory_arbiter_if #(.CPUS(CPUS)) bus ();

  memory_arbiter #(
    .CPUS    (CPUS),
    .TIMEOUT (4)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input int c, input logic r, input logic [31:0] a);
    bus.iREN[c]          = r;
    bus.iaddr[32*c +: 32] = a;
  endtask

  task automatic set_d(input int c, input logic ren, input logic wen, input logic [31:0] a,
                       input logic [31:0] s);
    bus.dREN[c]            = ren;
    bus.dWEN[c]            = wen;
    bus.daddr[32*c +: 32]  = a;
    bus.dstore[32*c +: 32] = s;
  endtask

  task automatic push(input int c, input bit data, input logic [31:0] load,
                      input logic [31:0] addr, input logic [31:0] store, input bit ren,
                      input bit wen);
    exp_t e;
    e.core  = c;
    e.data  = data;
    e.load  = load;
    e.addr  = addr;
    e.store = store;
    e.ren   = ren;
    e.wen   = wen;
    exp_q.push_back(e);
  endtask

  task automatic complete(input int c, input bit data);
    exp_t        e;
    logic [31:0] others;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_completion: got core %0d src %0d expected none (t=%0t)",
               c, data, $time);
      return;
    end
    e = exp_q.pop_front();
    chk("cpl_core", 32'(c), 32'(e.core));
    chk("cpl_src", 32'(data), 32'(e.data));
    chk("cpl_load", data ? bus.dload[32*c +: 32] : bus.iload[32*c +: 32], e.load);
    chk("cpl_ramaddr", bus.ramaddr, e.addr);
    chk("cpl_ramstore", bus.ramstore, e.store);
    chk("cpl_ramREN", 32'(bus.ramREN), 32'(e.ren));
    chk("cpl_ramWEN", 32'(bus.ramWEN), 32'(e.wen));
    chk("cpl_gnt_core", 32'(bus.gnt_core), 32'(e.core));
    others = '0;
    for (int k = 0; k < int'(CPUS); k++) begin
      if (!(k == c && !data)) others |= bus.iload[32*k +: 32];
      if (!(k == c && data))  others |= bus.dload[32*k +: 32];
    end
    chk("cpl_other_loads", others, 32'h0);
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < int'(CPUS); c++) begin
      if (bus.iREN[c] && !bus.iwait[c]) complete(c, 1'b0);
      if ((bus.dREN[c] || bus.dWEN[c]) && !bus.dwait[c]) complete(c, 1'b1);
    end
  end

  initial begin
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = RsFree;
    set_i(0, 1'b1, 32'h40);
    #3;
    chk("rst_gnt_valid", 32'(bus.gnt_valid), 32'h0);
    chk("rst_gnt_core", 32'(bus.gnt_core), 32'h0);
    chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_iload", bus.iload[31:0], 32'h0);
    chk("rst_mem_err", 32'(bus.mem_err), 32'h0);
    chk("rst_iwait_pending", 32'(bus.iwait[0]), 32'h1);

    // Single fetch, three BUSY cycles with ACCESS on the last.
    bus.ramstate = RsBusy;
    push(0, 1'b0, 32'h2402000A, 32'h40, 32'h0, 1'b1, 1'b0);
    nrst = 1'b1;
    tick();
    chk("f_ramREN", 32'(bus.ramREN), 32'h1);
    chk("f_ramaddr", bus.ramaddr, 32'h40);
    chk("f_gnt_valid", 32'(bus.gnt_valid), 32'h1);
    chk("f_iwait_busy", 32'(bus.iwait[0]), 32'h1);
    tick();
    tick();
    bus.ramstate = RsAccess;
    bus.ramload  = 32'h2402000A;
    tick();
    chk("f_idle_after", 32'(bus.gnt_valid), 32'h0);
    set_i(0, 1'b0, 32'h0);
    bus.ramstate = RsFree;

    // Data before instruction within one core.
    set_i(0, 1'b1, 32'h100);
    set_d(0, 1'b1, 1'b0, 32'h80, 32'h0);
    bus.ramstate = RsAccess;
    bus.ramload  = 32'h11112222;
    push(0, 1'b1, 32'h11112222, 32'h80, 32'h0, 1'b1, 1'b0);
    push(0, 1'b0, 32'h33334444, 32'h100, 32'h0, 1'b1, 1'b0);
    tick();
    chk("pri_ramaddr_data", bus.ramaddr, 32'h80);
    chk("pri_iwait_held", 32'(bus.iwait[0]), 32'h1);
    tick();
    set_d(0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.ramload = 32'h33334444;
    chk("pri_bubble_valid", 32'(bus.gnt_valid), 32'h0);
    chk("pri_bubble_iwait", 32'(bus.iwait[0]), 32'h1);
    tick();
    chk("pri_ramaddr_inst", bus.ramaddr, 32'h100);
    tick();
    set_i(0, 1'b0, 32'h0);
    bus.ramstate = RsFree;

    // Round robin with both cores writing; pointer was left at 1.
    set_d(0, 1'b0, 1'b1, 32'h1000, 32'hA0A0A0A0);
    set_d(1, 1'b0, 1'b1, 32'h2000, 32'hB1B1B1B1);
    bus.ramstate = RsAccess;
    bus.ramload  = 32'h55AA55AA;
    push(1, 1'b1, 32'h55AA55AA, 32'h2000, 32'hB1B1B1B1, 1'b0, 1'b1);
    push(0, 1'b1, 32'h55AA55AA, 32'h1000, 32'hA0A0A0A0, 1'b0, 1'b1);
    push(1, 1'b1, 32'h55AA55AA, 32'h2000, 32'hB1B1B1B1, 1'b0, 1'b1);
    push(0, 1'b1, 32'h55AA55AA, 32'h1000, 32'hA0A0A0A0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 0) chk("rr_bubble_dwait", 32'(bus.dwait), 32'h3);
    end
    set_d(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Read and write together resolve to a write.
    set_d(1, 1'b1, 1'b1, 32'h3000, 32'hDEADBEEF);
    bus.ramload = 32'hCAFEF00D;
    push(1, 1'b1, 32'hCAFEF00D, 32'h3000, 32'hDEADBEEF, 1'b0, 1'b1);
    tick();
    chk("col_ramWEN", 32'(bus.ramWEN), 32'h1);
    chk("col_ramREN", 32'(bus.ramREN), 32'h0);
    tick();
    set_d(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // ERROR abort.
    chk("err_mem_err_before", 32'(bus.mem_err), 32'h0);
    set_i(0, 1'b1, 32'h200);
    bus.ramstate = RsError;
    bus.ramload  = 32'h12345678;
    push(0, 1'b0, 32'hBAD1BAD1, 32'h200, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    chk("err_mem_err_set", 32'(bus.mem_err), 32'h1);
    set_i(0, 1'b0, 32'h0);

    // Timeout abort in the fourth BUSY cycle.
    set_d(0, 1'b1, 1'b0, 32'h400, 32'h0);
    bus.ramstate = RsBusy;
    push(0, 1'b1, 32'hBAD1BAD1, 32'h400, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk("tmo_third_dwait", 32'(bus.dwait[0]), 32'h1);
    tick();
    chk("tmo_fourth_dwait", 32'(bus.dwait[0]), 32'h0);
    tick();
    chk("tmo_idle", 32'(bus.gnt_valid), 32'h0);
    chk("tmo_mem_err_sticky", 32'(bus.mem_err), 32'h1);
    set_d(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Request drop: pointer stays at 1, so core 1 wins the next contest.
    set_i(1, 1'b1, 32'h500);
    tick();
    chk("drop_gnt_core", 32'(bus.gnt_core), 32'h1);
    chk("drop_ramaddr", bus.ramaddr, 32'h500);
    tick();
    set_i(1, 1'b0, 32'h500);
    #1;
    chk("drop_ramREN_same_cycle", 32'(bus.ramREN), 32'h0);
    chk("drop_iwait", 32'(bus.iwait[1]), 32'h0);
    tick();
    chk("drop_idle", 32'(bus.gnt_valid), 32'h0);
    set_d(0, 1'b1, 1'b0, 32'h600, 32'h0);
    set_d(1, 1'b1, 1'b0, 32'h700, 32'h0);
    bus.ramstate = RsAccess;
    bus.ramload  = 32'h77777777;
    push(1, 1'b1, 32'h77777777, 32'h700, 32'h0, 1'b1, 1'b0);
    tick();
    chk("drop_rr_kept", 32'(bus.gnt_core), 32'h1);
    chk("drop_loser_dwait", 32'(bus.dwait[0]), 32'h1);
    tick();
    set_d(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Asynchronous reset mid-BUSY, between clock edges.
    set_i(0, 1'b1, 32'h900);
    bus.ramstate = RsBusy;
    tick();
    chk("ar_busy", 32'(bus.gnt_valid), 32'h1);
    #2;
    nrst = 1'b0;
    #1;
    chk("ar_gnt_valid", 32'(bus.gnt_valid), 32'h0);
    chk("ar_gnt_core", 32'(bus.gnt_core), 32'h0);
    chk("ar_ramREN", 32'(bus.ramREN), 32'h0);
    chk("ar_ramaddr", bus.ramaddr, 32'h0);
    chk("ar_mem_err", 32'(bus.mem_err), 32'h0);
    chk("ar_iload", bus.iload[31:0], 32'h0);
    chk("ar_iwait", 32'(bus.iwait[0]), 32'h1);
    set_i(0, 1'b0, 32'h0);
    bus.ramstate = RsFree;
    nrst = 1'b1;
    tick();
    tick();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
